// File: rtl/encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_8_3_seq
//  Purpose  : Sequential 8-to-3 encoder. Accepts a multi-hot request vector
//             and emits the index of every set bit, highest index first, one
//             index per output handshake. An all-zero vector produces a
//             single "none" beat.
//  Revision : 1.0  initial release
// ============================================================================
module encoder_8_3_seq #(
   parameter int IDX_W = 3,
   parameter int WIDTH = 8
) (
   input  logic             clka,
   input  logic             rst,
   input  logic             E,
   input  logic [WIDTH-1:0] In,
   output logic             in_ready,
   output logic [IDX_W-1:0] Out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             last,
   output logic             none,
   output logic [IDX_W:0]   pop_cnt
);

   // WIDTH must equal 2**IDX_W so that every bit position has an index.
   localparam int C_WIDTH_CHK = 1 << IDX_W;

   // Build-time guard: a mismatched parameter pair has no legal encoding,
   // so elaboration is made to fail by instantiating a non-existent module.
   generate
      if (C_WIDTH_CHK != WIDTH) begin : g_bad_width
         encoder_8_3_seq_width_mismatch u_width_mismatch ();
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pend_q,  pend_d;
   logic [IDX_W-1:0] out_q,   out_d;
   logic             last_q,  last_d;
   logic             none_q,  none_d;
   logic [IDX_W:0]   pop_q,   pop_d;

   // -------------------------------------------------------------------------
   // Helper functions: priority scan from the top bit down, and popcount
   // -------------------------------------------------------------------------
   function automatic logic [IDX_W-1:0] f_highest(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      logic             found;
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   function automatic logic [IDX_W:0] f_popcount(input logic [WIDTH-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + {{IDX_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // -------------------------------------------------------------------------
   // Combinational views of the incoming vector and the remaining vector
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0] w_in_hi;
   logic [IDX_W:0]   w_in_pc;
   logic [WIDTH-1:0] w_pend_n;
   logic [IDX_W-1:0] w_pend_hi;
   logic [IDX_W:0]   w_pend_pc;
   logic             w_accept;
   logic             w_handshake;

   // Scan the input vector and the pending vector with the current bit removed.
   always_comb begin
      w_in_hi     = f_highest(In);
      w_in_pc     = f_popcount(In);
      w_pend_n    = pend_q & ~(WIDTH'(1) << out_q);
      w_pend_hi   = f_highest(w_pend_n);
      w_pend_pc   = f_popcount(w_pend_n);
      w_accept    = (state_q == S_IDLE) && E;
      w_handshake = (state_q == S_EMIT) && out_ready;
   end

   // -------------------------------------------------------------------------
   // FSM process 1: state register
   // -------------------------------------------------------------------------
   // Hold the current state; reset wins over any handshake in the same cycle.
   always_ff @(posedge clka) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // -------------------------------------------------------------------------
   // Leave IDLE on accept; leave EMIT once the final beat is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (E) begin
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_ready && last_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM process 3: state-decoded outputs
   // -------------------------------------------------------------------------
   // Handshake flags are pure functions of the state.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_EMIT);
   end

   // -------------------------------------------------------------------------
   // Datapath next-state
   // -------------------------------------------------------------------------
   // Load a new vector on accept, advance to the next set bit on handshake.
   always_comb begin
      pend_d = pend_q;
      out_d  = out_q;
      last_d = last_q;
      none_d = none_q;
      pop_d  = pop_q;
      if (w_accept) begin
         pend_d = In;
         pop_d  = w_in_pc;
         if (In != '0) begin
            out_d  = w_in_hi;
            last_d = (w_in_pc == (IDX_W + 1)'(1));
            none_d = 1'b0;
         end else begin
            out_d  = '0;
            last_d = 1'b1;
            none_d = 1'b1;
         end
      end else if (w_handshake) begin
         pend_d = w_pend_n;
         if (last_q) begin
            // Out and last keep their final values while idle.
            none_d = 1'b0;
         end else begin
            out_d  = w_pend_hi;
            last_d = (w_pend_pc == (IDX_W + 1)'(1));
         end
      end
   end

   // Datapath registers; reset discards any pending vector.
   always_ff @(posedge clka) begin
      if (rst) begin
         pend_q <= '0;
         out_q  <= '0;
         last_q <= 1'b0;
         none_q <= 1'b0;
         pop_q  <= '0;
      end else begin
         pend_q <= pend_d;
         out_q  <= out_d;
         last_q <= last_d;
         none_q <= none_d;
         pop_q  <= pop_d;
      end
   end

   // Registered beat fields drive the outputs directly.
   always_comb begin
      Out     = out_q;
      last    = last_q;
      none    = none_q;
      pop_cnt = pop_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_8_3_seq
//  Purpose  : Directed self-checking bench for encoder_8_3_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_encoder_8_3_seq;

   localparam int IDX_W = 3;
   localparam int WIDTH = 8;

   logic             clka;
   logic             rst;
   logic             E;
   logic [WIDTH-1:0] In;
   logic             in_ready;
   logic [IDX_W-1:0] Out;
   logic             out_valid;
   logic             out_ready;
   logic             last;
   logic             none;
   logic [IDX_W:0]   pop_cnt;

   int n_checks;
   int n_errors;

   encoder_8_3_seq #(
      .IDX_W (IDX_W),
      .WIDTH (WIDTH)
   ) u_dut (
      .clka      (clka),
      .rst       (rst),
      .E         (E),
      .In        (In),
      .in_ready  (in_ready),
      .Out       (Out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .last      (last),
      .none      (none),
      .pop_cnt   (pop_cnt)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Count one comparison and report it if the observed value is wrong.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      E         = 1'b1;
      In        = 8'hFF;
      out_ready = 1'b1;

      // Reset held for two cycles with a full vector presented.
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out", 32'(Out), 32'd0);
         chk("rst_pop", 32'(pop_cnt), 32'd0);
      end
      rst = 1'b0;
      E   = 1'b0;
      tick();
      chk("rst_no_beat", 32'(out_valid), 32'd0);

      // Basic vector 1010_0101: indices 7,5,2,0.
      E  = 1'b1;
      In = 8'b1010_0101;
      tick();
      E  = 1'b0;
      In = 8'h00;
      chk("basic_pop", 32'(pop_cnt), 32'd4);
      chk("basic_in_ready", 32'(in_ready), 32'd0);
      chk("basic_v0", 32'(out_valid), 32'd1);
      chk("basic_o0", 32'(Out), 32'd7);
      chk("basic_l0", 32'(last), 32'd0);
      chk("basic_n0", 32'(none), 32'd0);
      tick();
      chk("basic_o1", 32'(Out), 32'd5);
      chk("basic_l1", 32'(last), 32'd0);
      chk("basic_v1", 32'(out_valid), 32'd1);
      tick();
      chk("basic_o2", 32'(Out), 32'd2);
      chk("basic_l2", 32'(last), 32'd0);
      tick();
      chk("basic_o3", 32'(Out), 32'd0);
      chk("basic_l3", 32'(last), 32'd1);
      chk("basic_n3", 32'(none), 32'd0);
      chk("basic_v3", 32'(out_valid), 32'd1);
      tick();
      chk("basic_idle_rdy", 32'(in_ready), 32'd1);
      chk("basic_idle_v", 32'(out_valid), 32'd0);
      chk("basic_pop_hold", 32'(pop_cnt), 32'd4);

      // Backpressure with 0001_1000: Out=4 held three cycles, then 3.
      E         = 1'b1;
      In        = 8'b0001_1000;
      out_ready = 1'b0;
      tick();
      E  = 1'b0;
      In = 8'h00;
      for (int c = 0; c < 3; c++) begin
         chk("bp_stall_out", 32'(Out), 32'd4);
         chk("bp_stall_last", 32'(last), 32'd0);
         chk("bp_stall_v", 32'(out_valid), 32'd1);
         if (c < 2) tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_out2", 32'(Out), 32'd3);
      chk("bp_last2", 32'(last), 32'd1);
      chk("bp_v2", 32'(out_valid), 32'd1);
      chk("bp_pop", 32'(pop_cnt), 32'd2);
      tick();
      chk("bp_idle", 32'(in_ready), 32'd1);
      chk("bp_idle_v", 32'(out_valid), 32'd0);

      // Zero vector: a single none beat.
      E  = 1'b1;
      In = 8'h00;
      tick();
      E = 1'b0;
      chk("zero_v", 32'(out_valid), 32'd1);
      chk("zero_out", 32'(Out), 32'd0);
      chk("zero_none", 32'(none), 32'd1);
      chk("zero_last", 32'(last), 32'd1);
      chk("zero_pop", 32'(pop_cnt), 32'd0);
      tick();
      chk("zero_idle", 32'(in_ready), 32'd1);
      chk("zero_idle_v", 32'(out_valid), 32'd0);
      chk("zero_none_clr", 32'(none), 32'd0);

      // Full vector with E/In driven during emission.
      E  = 1'b1;
      In = 8'hFF;
      tick();
      In = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         chk("full_v", 32'(out_valid), 32'd1);
         chk("full_out", 32'(Out), 32'(i));
         chk("full_last", 32'(last), (i == 0) ? 32'd1 : 32'd0);
         chk("full_pop", 32'(pop_cnt), 32'd8);
         tick();
      end
      chk("full_idle", 32'(in_ready), 32'd1);
      chk("full_idle_v", 32'(out_valid), 32'd0);
      chk("full_pop_hold", 32'(pop_cnt), 32'd8);
      tick();
      E  = 1'b0;
      In = 8'h00;
      chk("next_v", 32'(out_valid), 32'd1);
      chk("next_out", 32'(Out), 32'd0);
      chk("next_last", 32'(last), 32'd1);
      chk("next_none", 32'(none), 32'd0);
      chk("next_pop", 32'(pop_cnt), 32'd1);
      tick();
      chk("next_idle", 32'(in_ready), 32'd1);

      // Reset in the middle of emitting 1100_0011.
      E  = 1'b1;
      In = 8'b1100_0011;
      tick();
      E  = 1'b0;
      In = 8'h00;
      chk("mid_o0", 32'(Out), 32'd7);
      tick();
      chk("mid_o1", 32'(Out), 32'd6);
      chk("mid_pop", 32'(pop_cnt), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_v", 32'(out_valid), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready), 32'd1);
      chk("mid_rst_pop", 32'(pop_cnt), 32'd0);
      chk("mid_rst_out", 32'(Out), 32'd0);
      E  = 1'b1;
      In = 8'h02;
      tick();
      E  = 1'b0;
      In = 8'h00;
      chk("post_v", 32'(out_valid), 32'd1);
      chk("post_out", 32'(Out), 32'd1);
      chk("post_last", 32'(last), 32'd1);
      chk("post_pop", 32'(pop_cnt), 32'd1);
      tick();
      chk("post_idle", 32'(in_ready), 32'd1);
      chk("post_idle_v", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/encoder_8_3_seq.md
Name: encoder_8_3_seq

Overview:
Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder. It accepts a multi-hot 8-bit vector and emits the 3-bit index of every set bit, one index per output handshake. Order is highest index first. The block sits between request-vector producers and index-consuming logic, and serialises simultaneous requests that the decoder would otherwise have to regenerate one at a time.

Parameters:
IDX_W, 3, index width; Out width.
WIDTH, 8, input vector width; must equal 2**IDX_W.

Ports:
clka  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
E  input  1  input valid/enable; vector accepted when E && in_ready
In  input  WIDTH  request vector
in_ready  output  1  block idle, can accept a vector
Out  output  IDX_W  encoded index of current beat
out_valid  output  1  Out/last/none valid
out_ready  input  1  consumer accepts beat when out_valid && out_ready
last  output  1  current beat is final beat of the vector
none  output  1  current beat reports an all-zero vector (Out=0)
pop_cnt  output  IDX_W+1  number of set bits in most recently accepted vector

Behaviour:
- Reset (rst=1 at clka edge) produces the following state: IDLE, pend=0, Out=0, out_valid=0, last=0, none=0, pop_cnt=0, in_ready=1. Reset takes priority over every other event, including mid-emission; the pending vector is discarded.
- The state machine has two states, IDLE and EMIT. in_ready=1 exactly when state==IDLE. out_valid=1 exactly when state==EMIT.
- IDLE:
  - E=0: stay in IDLE; all outputs hold their values except out_valid=0.
  - E=1 and accept, In!=0:
    - pend<=In; pop_cnt<=popcount(In).
    - Out<=index of highest set bit of In.
    - last<=(popcount(In)==1); none<=0.
    - Go to EMIT.
  - E=1 and accept, In==0:
    - pend<=0; pop_cnt<=0; Out<=0.
    - last<=1; none<=1.
    - Go to EMIT. A single "none" beat follows.
- Latency: the first out_valid occurs in the cycle after the accept edge.
- EMIT:
  - out_valid=1. Out, last and none come from registers and stay stable while out_ready=0.
  - On the handshake edge, the bit Out is cleared: pend_n = pend with bit Out cleared.
    - If last=1: go to IDLE; out_valid falls and in_ready rises in the next cycle; none<=0.
    - Otherwise: Out<=highest set bit of pend_n; last<=(popcount(pend_n)==1).
  - E is ignored in EMIT, because in_ready=0; In changes have no effect.
- Throughput:
  - A vector with k set bits, out_ready held at 1, takes exactly k EMIT cycles and 1 IDLE cycle before the next accept. A zero vector takes 1 EMIT cycle.
  - There are no bubbles between beats of one vector.
- Width rules:
  - The priority search is a pure combinational scan from bit WIDTH-1 down to bit 0.
  - pop_cnt is IDX_W+1 bits so it can represent WIDTH (8 = 4'b1000).
- pop_cnt updates only at accept and holds through EMIT and IDLE until the next accept or reset.
- The handshake edge and reset in the same cycle resolve to reset.

Test Plan:
- Reset: assert rst for 2 cycles with E=1, In=8'hFF. Required: in_ready=1, out_valid=0, Out=0, pop_cnt=0 throughout; no beat is emitted.
- Basic vector: E=1, In=8'b1010_0101 for one cycle, out_ready=1.
  - pop_cnt=4.
  - Out sequence is 7,5,2,0 on four consecutive cycles starting the cycle after accept.
  - last=1 only with Out=0; none=0 throughout.
  - in_ready=1 on the cycle after the last beat.
- Backpressure: In=8'b0001_1000, with out_ready=0 for 3 cycles then 1. Required: Out=4 and last=0 held stable for all 3 stalled cycles, then Out=3 with last=1, then IDLE.
- Zero vector: In=8'h00. Required: exactly one beat with Out=0, none=1, last=1, pop_cnt=0, then in_ready=1.
- Full vector and busy input: In=8'hFF with out_ready=1; drive E=1, In=8'h01 during emission.
  - Required: 8 back-to-back beats, Out=7..0, pop_cnt=4'b1000.
  - The mid-emission input is ignored, with no extra beat.
  - A new accept becomes possible the cycle after Out=0.
- Reset mid-operation: In=8'b1100_0011, assert rst after the second beat (Out=6). Required next cycle: out_valid=0, in_ready=1, pop_cnt=0. A following accept of 8'h02 yields a single beat Out=1, last=1.
